// File: rtl/adsr_voice_sequencer_if.sv
// Voice-context bus between the ADSR sequencer and the ADSR update stage.
// The master presents one stored context and takes back the updated one.
interface adsr_voice_sequencer_if;
  logic [2:0]  o_adsr_state;
  logic [17:0] o_adsr_volume;
  logic        o_adsr_pressed;
  logic        o_adsr_released;
  logic [2:0]  i_adsr_state;
  logic [17:0] i_adsr_volume;
  logic        i_adsr_pressed;
  logic        i_adsr_released;

  modport master (
    output o_adsr_state,
    output o_adsr_volume,
    output o_adsr_pressed,
    output o_adsr_released,
    input  i_adsr_state,
    input  i_adsr_volume,
    input  i_adsr_pressed,
    input  i_adsr_released
  );

  modport slave (
    input  o_adsr_state,
    input  o_adsr_volume,
    input  o_adsr_pressed,
    input  o_adsr_released,
    output i_adsr_state,
    output i_adsr_volume,
    output i_adsr_pressed,
    output i_adsr_released
  );
endinterface

// File: rtl/adsr_voice_sequencer.sv
// Per-voice ADSR context store; sweeps one shared ADSR stage over all
// voices once per envelope tick and streams the updated volumes out.
module adsr_voice_sequencer #(
  parameter int NB_VOICE = 16,
  parameter int VOICE_W  = 4,
  parameter int TICK_DIV = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_event_valid,
  input  logic [VOICE_W-1:0]  i_event_voice,
  input  logic                i_event_on,
  adsr_voice_sequencer_if.master adsr,
  output logic                o_vol_valid,
  output logic [VOICE_W-1:0]  o_vol_voice,
  output logic [17:0]         o_volume,
  output logic [NB_VOICE-1:0] o_voice_active,
  output logic                o_overrun
);
  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic {IDLE, SWEEP} fsm_e;

  fsm_e                fsm_q, fsm_d;
  logic [VOICE_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick;
  logic                ovr_q, ovr_d;
  logic [2:0]          st_q  [NB_VOICE];
  logic [2:0]          st_d  [NB_VOICE];
  logic [17:0]         vol_q [NB_VOICE];
  logic [17:0]         vol_d [NB_VOICE];
  logic [NB_VOICE-1:0] prs_q, prs_d;
  logic [NB_VOICE-1:0] rel_q, rel_d;
  logic [NB_VOICE-1:0] act_q, act_d;
  logic                vld_q, vld_d;
  logic [VOICE_W-1:0]  vvc_q, vvc_d;
  logic [17:0]         ovol_q, ovol_d;

  assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  assign adsr.o_adsr_state    = st_q[idx_q];
  assign adsr.o_adsr_volume   = vol_q[idx_q];
  assign adsr.o_adsr_pressed  = prs_q[idx_q];
  assign adsr.o_adsr_released = rel_q[idx_q];

  always_comb begin
    fsm_d  = fsm_q;
    idx_d  = idx_q;
    ovr_d  = ovr_q;
    st_d   = st_q;
    vol_d  = vol_q;
    prs_d  = prs_q;
    rel_d  = rel_q;
    vld_d  = 1'b0;
    vvc_d  = vvc_q;
    ovol_d = ovol_q;
    act_d  = '0;
    case (fsm_q)
      IDLE: begin
        if (tick) begin
          fsm_d = SWEEP;
          idx_d = '0;
        end
      end
      SWEEP: begin
        if (tick) ovr_d = 1'b1;
        st_d[idx_q]  = adsr.i_adsr_state;
        vol_d[idx_q] = adsr.i_adsr_volume;
        prs_d[idx_q] = adsr.i_adsr_pressed;
        rel_d[idx_q] = adsr.i_adsr_released;
        vld_d  = 1'b1;
        vvc_d  = idx_q;
        ovol_d = adsr.i_adsr_volume;
        if (idx_q == VOICE_W'(NB_VOICE - 1)) begin
          fsm_d = IDLE;
          idx_d = '0;
        end else begin
          idx_d = idx_q + VOICE_W'(1);
        end
      end
      default: ;
    endcase
    // Events OR on top of the write-back so a colliding event survives.
    if (i_event_valid) begin
      if (i_event_on) prs_d[i_event_voice] = 1'b1;
      else            rel_d[i_event_voice] = 1'b1;
    end
    for (int v = 0; v < NB_VOICE; v++) begin
      act_d[v] = (st_d[v] != 3'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= IDLE;
      idx_q  <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      prs_q  <= '0;
      rel_q  <= '0;
      act_q  <= '0;
      vld_q  <= 1'b0;
      vvc_q  <= '0;
      ovol_q <= '0;
      for (int v = 0; v < NB_VOICE; v++) begin
        st_q[v]  <= 3'd0;
        vol_q[v] <= 18'd0;
      end
    end else begin
      fsm_q  <= fsm_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
      prs_q  <= prs_d;
      rel_q  <= rel_d;
      act_q  <= act_d;
      vld_q  <= vld_d;
      vvc_q  <= vvc_d;
      ovol_q <= ovol_d;
      for (int v = 0; v < NB_VOICE; v++) begin
        st_q[v]  <= st_d[v];
        vol_q[v] <= vol_d[v];
      end
    end
  end

  assign o_vol_valid    = vld_q;
  assign o_vol_voice    = vvc_q;
  assign o_volume       = ovol_q;
  assign o_voice_active = act_q;
  assign o_overrun      = ovr_q;
endmodule

// File: tb/tb_adsr_voice_sequencer.sv
// Bench for adsr_voice_sequencer: cycle-level voice-context model,
// flag-collision vector table, ADSR envelope sequences, overrun instance.
module tb_adsr_voice_sequencer;
  localparam int NV  = 16;
  localparam int VW  = 4;
  localparam int TD  = 32;
  localparam int TD2 = 16;
  localparam int AR  = 64;
  localparam int RR  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ev_valid = 1'b0;
  logic [VW-1:0] ev_voice = '0;
  logic          ev_on = 1'b0;
  logic          vld;
  logic [VW-1:0] vvc;
  logic [17:0]   vol;
  logic [NV-1:0] act;
  logic          ovr;

  logic          ev2_valid = 1'b0;
  logic [VW-1:0] ev2_voice = '0;
  logic          ev2_on = 1'b0;
  logic          vld2;
  logic [VW-1:0] vvc2;
  logic [17:0]   vol2;
  logic [NV-1:0] act2;
  logic          ovr2;

  adsr_voice_sequencer_if bus();
  adsr_voice_sequencer_if bus2();

  adsr_voice_sequencer #(
    .NB_VOICE(NV), .VOICE_W(VW), .TICK_DIV(TD)
  ) u_dut (
    .clk(clk), .rst(rst),
    .i_event_valid(ev_valid), .i_event_voice(ev_voice),
    .i_event_on(ev_on), .adsr(bus),
    .o_vol_valid(vld), .o_vol_voice(vvc), .o_volume(vol),
    .o_voice_active(act), .o_overrun(ovr)
  );

  // Tick period equal to the sweep length: every second tick overruns.
  adsr_voice_sequencer #(
    .NB_VOICE(NV), .VOICE_W(VW), .TICK_DIV(TD2)
  ) u_dut2 (
    .clk(clk), .rst(rst),
    .i_event_valid(ev2_valid), .i_event_voice(ev2_voice),
    .i_event_on(ev2_on), .adsr(bus2),
    .o_vol_valid(vld2), .o_vol_voice(vvc2), .o_volume(vol2),
    .o_voice_active(act2), .o_overrun(ovr2)
  );

  int total = 0;
  int bad = 0;
  int c = 0;
  int mode = 0;
  logic frc_en = 1'b0;
  logic frc_p = 1'b0;
  logic frc_r = 1'b0;

  logic [2:0]    m_st  [NV];
  logic [17:0]   m_vol [NV];
  logic [NV-1:0] m_prs, m_rel;
  logic          e_vld;
  logic [VW-1:0] e_vv;
  logic [17:0]   e_vol;
  logic [17:0]   e2_vol;

  typedef struct {
    logic          ev_valid;
    logic [VW-1:0] ev_voice;
    logic          ev_on;
    logic          nxt_p;
    logic          nxt_r;
    logic          exp_p;
    logic          exp_r;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
    end
  endtask

  task automatic model_reset();
    c = 0;
    for (int i = 0; i < NV; i++) begin
      m_st[i]  = 3'd0;
      m_vol[i] = 18'd0;
    end
    m_prs  = '0;
    m_rel  = '0;
    e_vld  = 1'b0;
    e_vv   = '0;
    e_vol  = '0;
    e2_vol = '0;
  endtask

  // Simple envelope: press -> ATTACK at 0, ramp by AR; release -> RELEASE,
  // ramp down by RR until the subtraction borrows, then BLANK.
  function automatic void adsr_fn(
    input  logic [2:0] st, input logic [17:0] v,
    input  logic p, input logic r,
    output logic [2:0] ns, output logic [17:0] nv,
    output logic np, output logic nr);
    logic [17:0] t;
    ns = st; nv = v; np = p; nr = r;
    if (p) begin
      ns = 3'd1; nv = 18'd0; np = 1'b0;
    end else if (r) begin
      nr = 1'b0;
      if (st != 3'd0) ns = 3'd4;
    end else if (st == 3'd1) begin
      nv = v + 18'(AR);
    end else if (st == 3'd4) begin
      t = v - 18'(RR);
      if (t[17]) begin
        ns = 3'd0; nv = 18'd0;
      end else begin
        nv = t;
      end
    end
  endfunction

  task automatic step(input logic v, input logic [VW-1:0] vv,
                      input logic on);
    logic sw, sw2, ew2;
    int k, pc;
    logic [2:0] ns;
    logic [17:0] nv;
    logic np, nr;
    logic [NV-1:0] ea;
    sw = (c >= TD) && ((c % TD) < NV);
    k = sw ? (c % TD) : 0;
    ns = m_st[k]; nv = m_vol[k]; np = m_prs[k]; nr = m_rel[k];
    if (mode == 1) begin
      ns = 3'($urandom); nv = 18'($urandom);
      np = 1'($urandom); nr = 1'($urandom);
    end else if (mode == 2) begin
      adsr_fn(m_st[k], m_vol[k], m_prs[k], m_rel[k], ns, nv, np, nr);
    end
    if (frc_en && sw && k == 7) begin
      np = frc_p; nr = frc_r;
    end
    ev_valid = v; ev_voice = vv; ev_on = on;
    bus.i_adsr_state    = ns;
    bus.i_adsr_volume   = nv;
    bus.i_adsr_pressed  = np;
    bus.i_adsr_released = nr;
    bus2.i_adsr_state    = 3'd0;
    bus2.i_adsr_volume   = 18'($urandom);
    bus2.i_adsr_pressed  = 1'b0;
    bus2.i_adsr_released = 1'b0;
    #1;
    for (int i = 0; i < NV; i++) ea[i] = (m_st[i] != 3'd0);
    chk("cur_state", bus.o_adsr_state, m_st[k]);
    chk("cur_volume", bus.o_adsr_volume, m_vol[k]);
    chk("cur_pressed", bus.o_adsr_pressed, m_prs[k]);
    chk("cur_released", bus.o_adsr_released, m_rel[k]);
    chk("vol_valid", vld, e_vld);
    chk("vol_voice", vvc, e_vv);
    chk("volume", vol, e_vol);
    chk("active", act, ea);
    chk("overrun", ovr, 1'b0);
    pc = c - 1;
    ew2 = 1'b0;
    if (pc >= TD2) ew2 = (((pc - TD2) % (2 * TD2)) < NV);
    chk("vol_valid2", vld2, ew2);
    if (ew2) begin
      chk("vol_voice2", vvc2, (pc - TD2) % (2 * TD2));
      chk("volume2", vol2, e2_vol);
    end
    chk("overrun2", ovr2, (c >= 2 * TD2));
    if (sw) begin
      m_st[k] = ns; m_vol[k] = nv; m_prs[k] = np; m_rel[k] = nr;
    end
    if (v) begin
      if (on) m_prs[vv] = 1'b1;
      else    m_rel[vv] = 1'b1;
    end
    e_vld = sw;
    if (sw) begin
      e_vv = VW'(k); e_vol = nv;
    end
    sw2 = (c >= TD2) && (((c - TD2) % (2 * TD2)) < NV);
    if (sw2) e2_vol = bus2.i_adsr_volume;
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0);
  endtask

  // Advance until the current cycle is the write-back cycle of voice k.
  task automatic run_to(input int k);
    int n;
    n = 0;
    while (!((c >= TD) && ((c % TD) == k)) && n < 3 * TD) begin
      idle();
      n++;
    end
    if (n >= 3 * TD) begin
      bad++;
      $display("FAIL run_to timeout voice=%0d", k);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic env_sweep(input logic [17:0] ev, input logic [NV-1:0] ea);
    run_to(3);
    idle();
    chk("env_valid", vld, 1'b1);
    chk("env_voice", vvc, 4'd3);
    chk("env_volume", vol, ev);
    chk("env_active", act, ea);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    tbl[0] = '{1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    bus.i_adsr_state = '0;  bus.i_adsr_volume = '0;
    bus.i_adsr_pressed = 1'b0;  bus.i_adsr_released = 1'b0;
    bus2.i_adsr_state = '0; bus2.i_adsr_volume = '0;
    bus2.i_adsr_pressed = 1'b0; bus2.i_adsr_released = 1'b0;
    model_reset();
    #2;
    chk("rst_valid", vld, 1'b0);
    chk("rst_active", act, '0);
    chk("rst_volume", vol, '0);
    chk("rst_overrun", ovr, 1'b0);
    chk("rst_cur_state", bus.o_adsr_state, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    mode = 1;
    for (int i = 0; i < 20 * TD; i++) begin
      step(($urandom % 4) == 0, VW'($urandom), 1'($urandom));
    end

    run_to(5);
    rst = 1'b1;
    #1;
    chk("midrst_valid", vld, 1'b0);
    chk("midrst_active", act, '0);
    chk("midrst_cur_state", bus.o_adsr_state, '0);
    chk("midrst_cur_volume", bus.o_adsr_volume, '0);
    chk("midrst_cur_flags", {bus.o_adsr_pressed, bus.o_adsr_released}, '0);
    chk("midrst_overrun2", ovr2, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mode = 0;
    for (int i = 0; i < 3 * TD; i++) idle();

    mode = 1;
    for (int i = 0; i < 4 * TD; i++) begin
      step(($urandom % 3) == 0, VW'($urandom), 1'($urandom));
    end
    mode = 0;
    for (int i = 0; i < 8; i++) begin
      run_to(7);
      frc_en = 1'b1; frc_p = tbl[i].nxt_p; frc_r = tbl[i].nxt_r;
      step(tbl[i].ev_valid, tbl[i].ev_voice, tbl[i].ev_on);
      frc_en = 1'b0;
      run_to(7);
      chk("tbl_pressed", bus.o_adsr_pressed, tbl[i].exp_p);
      chk("tbl_released", bus.o_adsr_released, tbl[i].exp_r);
    end

    do_reset();
    mode = 2;
    for (int i = 0; i < TD + 4; i++) idle();
    step(1'b1, 4'd3, 1'b1);
    env_sweep(18'd0, 16'h0008);
    run_to(3);
    chk("attack_state", bus.o_adsr_state, 3'd1);
    chk("attack_pressed", bus.o_adsr_pressed, 1'b0);
    env_sweep(18'd64, 16'h0008);
    env_sweep(18'd128, 16'h0008);
    env_sweep(18'd192, 16'h0008);
    run_to(20);
    step(1'b1, 4'd3, 1'b0);
    env_sweep(18'd192, 16'h0008);
    run_to(3);
    chk("release_state", bus.o_adsr_state, 3'd4);
    env_sweep(18'd92, 16'h0008);
    env_sweep(18'd0, 16'h0000);
    run_to(3);
    chk("blank_state", bus.o_adsr_state, 3'd0);
    for (int i = 0; i < TD; i++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
